elim_ctrl: RTL and testbench
============================

ELIM_CTRL -- requirements
Module: elim_ctrl

Interface
REQ-001 Parameter MAX_MOVES, default 20, moves allowed per round (1..63).
REQ-002 Parameter ELIM_TIMEOUT, default 4, cycles to wait for elim_done before abandoning a move (1..15).
REQ-003 clk  input  1  single system clock, all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 btn_up, btn_down, btn_left, btn_right  input  1 each  single-cycle cursor move pulses.
REQ-006 btn_ok  input  1  single-cycle pulse requesting elimination at the cursor.
REQ-007 btn_new  input  1  single-cycle pulse requesting a new round.
REQ-008 gen_done  input  1  board generator finished; gen_board valid in that cycle.
REQ-009 gen_board  input  192  generated board, cell (x,y) at bits [(8x+y)*3 +: 3], where 0 means empty.
REQ-010 elim_board  input  192  board returned by the eliminate datapath.
REQ-011 elim_done  input  1  datapath eliminated flag.
REQ-012 gen_req  output  1  one-cycle request to the board generator.
REQ-013 cursor_x, cursor_y  output  4 each  cursor coordinates, range 0..7.
REQ-014 confirm  output  1  datapath confirm strobe.
REQ-015 board  output  192  committed board register.
REQ-016 score  output  7  round score, 0..99.
REQ-017 moves_left  output  6  remaining moves.
REQ-018 busy  output  1  high in every state except PLAY and OVER.
REQ-019 game_over  output  1  high in OVER.

Function
REQ-020 FSM states: IDLE, GEN, PLAY, ARM, FIRE, WAIT, COMMIT, OVER.
REQ-021 IDLE: on btn_new, pulse gen_req for one cycle and go to GEN.
REQ-022 GEN: on gen_done, board<=gen_board, score<=0, moves_left<=MAX_MOVES, cursor<=(0,0), generated to PLAY.
REQ-023 PLAY: each move pulse steps the cursor by ±1 in the next cycle; only one pulse applies per cycle, with priority up>down>left>right.
REQ-024 up/down change cursor_x, left/right change cursor_y.
REQ-025 PLAY: btn_ok goes to ARM when board cell at cursor is nonzero, otherwise it is ignored; btn_new in PLAY behaves as in IDLE.
REQ-026 ARM: confirm=0 for exactly one cycle so the datapath samples neighbour marks, then go to FIRE; cursor is frozen from ARM through COMMIT.
REQ-027 FIRE: confirm=1 for exactly one cycle, then go to WAIT with the timeout counter cleared.
REQ-028 WAIT: confirm=0; on elim_done go to COMMIT.
REQ-029 WAIT: when the counter reaches ELIM_TIMEOUT without elim_done, return to PLAY; board, score and moves_left are unchanged.
REQ-030 COMMIT: board<=elim_board and score<=min(99, score+cleared); moves_left decrements by 1.
REQ-031 cleared = count of cells nonzero in board and zero in elim_board, computed at 7-bit width with no wrap.
REQ-032 COMMIT: if the decremented moves_left is 0, go to OVER, else go to PLAY.
REQ-033 OVER: all move and ok pulses are ignored; btn_new behaves as in IDLE.
REQ-034 If elim_done and btn_new arrive in the same WAIT cycle, elim_done wins and btn_new is dropped.
REQ-035 Inputs arriving in GEN, ARM, FIRE, WAIT or COMMIT are discarded, not queued.

Reset
REQ-036 rst_n low immediately forces IDLE, including mid-elimination.
REQ-037 rst_n low clears board, score, cursor and counters to 0.
REQ-038 rst_n low sets confirm, gen_req, busy and game_over to 0 and moves_left to 0.
REQ-039 Outputs are defined from the first edge after rst_n deasserts.

Configuration
REQ-040 ELIM_CTRL_CURSOR_WRAP_EN defined: cursor wraps at the edges, 7+1 becomes 0 and 0-1 becomes 7.
REQ-041 ELIM_CTRL_CURSOR_WRAP_EN undefined: cursor saturates at 0 and 7.

Verification
REQ-042 Reset then btn_new; gen_done with a checkerboard board -> gen_req pulses once, PLAY, score=0, moves_left=20, cursor (0,0).
REQ-043 Cursor at (0,0), btn_up -> cursor_x stays 0 without the macro and becomes 7 with it; three btn_right -> cursor_y=3.
REQ-044 btn_ok on a nonzero cell; elim_done two cycles after FIRE with elim_board clearing 3 cells.
REQ-045 Expected response for REQ-044: confirm sequence 0,1,0; board updated; score=3; moves_left=19.
REQ-046 btn_ok with elim_done never asserted -> return to PLAY after 4 WAIT cycles with board, score and moves unchanged.
REQ-047 Score 98 and 5 cells cleared -> score=99; with moves_left=1, a commit gives moves_left=0 and game_over=1, and btn_ok is ignored afterwards.
REQ-048 rst_n asserted during WAIT -> IDLE at once, confirm=0, board=0; elim_done arriving afterwards has no effect.

Source files
------------

// File: rtl/elim_ctrl_if.sv
// Bundle of the elim_ctrl button, generator, datapath and status signals.
// The slave side is the controller; the master side is whatever drives the controller.
interface elim_ctrl_if;
    logic         btn_up;
    logic         btn_down;
    logic         btn_left;
    logic         btn_right;
    logic         btn_ok;
    logic         btn_new;
    logic         gen_done;
    logic [191:0] gen_board;
    logic [191:0] elim_board;
    logic         elim_done;
    logic         gen_req;
    logic [3:0]   cursor_x;
    logic [3:0]   cursor_y;
    logic         confirm;
    logic [191:0] board;
    logic [6:0]   score;
    logic [5:0]   moves_left;
    logic         busy;
    logic         game_over;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_ok, btn_new,
        output gen_done, gen_board, elim_board, elim_done,
        input  gen_req, cursor_x, cursor_y, confirm, board, score,
        input  moves_left, busy, game_over
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_ok, btn_new,
        input  gen_done, gen_board, elim_board, elim_done,
        output gen_req, cursor_x, cursor_y, confirm, board, score,
        output moves_left, busy, game_over
    );
endinterface

// File: rtl/elim_ctrl.sv
// Round/move sequencer for a cell-elimination game: cursor, confirm handshake, scoring.
// Define ELIM_CTRL_CURSOR_WRAP_EN to make the cursor wrap at the board edges instead of saturating.
//
// state  | meaning
// IDLE   | no round, waiting for btn_new
// GEN    | waiting for the board generator
// PLAY   | cursor moves and btn_ok accepted
// ARM    | confirm low one cycle, datapath samples marks
// FIRE   | confirm high one cycle
// WAIT   | waiting for elim_done, bounded by ELIM_TIMEOUT
// COMMIT | load eliminated board, score, spend a move
// OVER   | round finished, only btn_new accepted
module elim_ctrl #(
    parameter int MAX_MOVES    = 20,
    parameter int ELIM_TIMEOUT = 4
) (
    input logic        clk,
    input logic        rst_n,
    elim_ctrl_if.slave bus_io
);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_PLAY, S_ARM, S_FIRE, S_WAIT, S_COMMIT, S_OVER
    } state_t;

    state_t         state_q, state_d;
    logic [191:0]   board_q, board_d;
    logic [6:0]     score_q, score_d;
    logic [5:0]     moves_q, moves_d;
    logic [3:0]     cur_x_q, cur_x_d;
    logic [3:0]     cur_y_q, cur_y_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           gen_req_q, gen_req_d;
    logic           confirm_q, confirm_d;
    logic           busy_q, busy_d;
    logic           game_over_q, game_over_d;

    logic [7:0]     cell_idx;
    logic [9:0]     cell_base;
    logic           cell_nz;
    logic [6:0]     cleared;
    logic [7:0]     score_sum;
    logic [5:0]     moves_dec;

    function automatic logic [3:0] cur_inc(input logic [3:0] v);
`ifdef ELIM_CTRL_CURSOR_WRAP_EN
        return (v >= 4'd7) ? 4'd0 : v + 4'd1;
`else
        return (v >= 4'd7) ? 4'd7 : v + 4'd1;
`endif
    endfunction

    function automatic logic [3:0] cur_dec(input logic [3:0] v);
`ifdef ELIM_CTRL_CURSOR_WRAP_EN
        return (v == 4'd0) ? 4'd7 : v - 4'd1;
`else
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
`endif
    endfunction

    assign cell_idx  = {1'b0, cur_x_q, 3'b000} + {4'b0000, cur_y_q};
    assign cell_base = 10'(cell_idx) * 10'd3;
    assign cell_nz   = (board_q[cell_base +: 3] != 3'd0);
    assign moves_dec = moves_q - 6'd1;
    assign score_sum = {1'b0, score_q} + {1'b0, cleared};

    always_comb begin
        cleared = '0;
        for (int i = 0; i < 64; i++) begin
            if ((board_q[i*3 +: 3] != 3'd0) && (bus_io.elim_board[i*3 +: 3] == 3'd0))
                cleared = cleared + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gen_req_q   <= 1'b0;
            confirm_q   <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_req_q   <= gen_req_d;
            confirm_q   <= confirm_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    // btn_new is tested before btn_ok so a new-round request always wins in PLAY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus_io.btn_new) state_d = S_GEN;
            S_GEN:    if (bus_io.gen_done) state_d = S_PLAY;
            S_PLAY: begin
                if (bus_io.btn_new)                state_d = S_GEN;
                else if (bus_io.btn_ok && cell_nz) state_d = S_ARM;
            end
            S_ARM:    state_d = S_FIRE;
            S_FIRE:   state_d = S_WAIT;
            S_WAIT: begin
                if (bus_io.elim_done)                     state_d = S_COMMIT;
                else if (cnt_q == 4'(ELIM_TIMEOUT - 1))   state_d = S_PLAY;
            end
            S_COMMIT: state_d = (moves_dec == 6'd0) ? S_OVER : S_PLAY;
            S_OVER:   if (bus_io.btn_new) state_d = S_GEN;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        gen_req_d   = (state_d == S_GEN) && (state_q != S_GEN);
        confirm_d   = (state_d == S_FIRE);
        busy_d      = (state_d != S_PLAY) && (state_d != S_OVER);
        game_over_d = (state_d == S_OVER);
    end

    always_comb begin
        board_d = board_q;
        score_d = score_q;
        moves_d = moves_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_GEN: begin
                if (bus_io.gen_done) begin
                    board_d = bus_io.gen_board;
                    score_d = 7'd0;
                    moves_d = 6'(MAX_MOVES);
                    cur_x_d = 4'd0;
                    cur_y_d = 4'd0;
                end
            end
            S_PLAY: begin
                if (bus_io.btn_up)         cur_x_d = cur_dec(cur_x_q);
                else if (bus_io.btn_down)  cur_x_d = cur_inc(cur_x_q);
                else if (bus_io.btn_left)  cur_y_d = cur_dec(cur_y_q);
                else if (bus_io.btn_right) cur_y_d = cur_inc(cur_y_q);
            end
            S_FIRE: cnt_d = 4'd0;
            S_WAIT: cnt_d = cnt_q + 4'd1;
            S_COMMIT: begin
                board_d = bus_io.elim_board;
                score_d = (score_sum > 8'd99) ? 7'd99 : score_sum[6:0];
                moves_d = moves_dec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q <= '0;
            score_q <= '0;
            moves_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            board_q <= board_d;
            score_q <= score_d;
            moves_q <= moves_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_io.gen_req    = gen_req_q;
    assign bus_io.confirm    = confirm_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.game_over  = game_over_q;
    assign bus_io.board      = board_q;
    assign bus_io.score      = score_q;
    assign bus_io.moves_left = moves_q;
    assign bus_io.cursor_x   = cur_x_q;
    assign bus_io.cursor_y   = cur_y_q;

endmodule

// File: tb/tb_elim_ctrl.sv
// Directed bench for elim_ctrl: round start, cursor, move commit, timeout, score clamp, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_elim_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    elim_ctrl_if bus();

    elim_ctrl #(.MAX_MOVES(20), .ELIM_TIMEOUT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [191:0] checker_board();
        logic [191:0] b;
        b = '0;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                b[(8*x+y)*3 +: 3] = (((x + y) % 2) == 0) ? 3'd2 : 3'd0;
        return b;
    endfunction

    // All cells 1, except cells lo..hi which are empty.
    function automatic logic [191:0] fill_board(input int lo, input int hi);
        logic [191:0] b;
        b = '0;
        for (int i = 0; i < 64; i++)
            b[i*3 +: 3] = (i >= lo && i <= hi) ? 3'd0 : 3'd1;
        return b;
    endfunction

    // Starts on a falling edge in PLAY with the cursor on a nonzero cell; ends on a falling edge
    // after the controller is back in PLAY/OVER. conf = {WAIT, FIRE, ARM} confirm samples.
    task automatic do_move(input logic [191:0] eb, input bit give_done, input bit new_too,
                           output logic [2:0] conf);
        bus.elim_board = eb;
        bus.btn_ok = 1'b1;
        step();
        bus.btn_ok = 1'b0;
        bus.btn_right = 1'b1;
        conf[0] = bus.confirm;
        step();
        bus.btn_right = 1'b0;
        bus.btn_up = 1'b1;
        conf[1] = bus.confirm;
        step();
        bus.btn_up = 1'b0;
        conf[2] = bus.confirm;
        if (give_done) begin
            step();
            bus.elim_done = 1'b1;
            bus.btn_new = new_too;
            step();
            bus.elim_done = 1'b0;
            bus.btn_new = 1'b0;
            if (new_too) check_val("collide_gen_req", bus.gen_req, 0);
            step();
        end else begin
            step();
            step();
            step();
            check_val("wait_last_busy", bus.busy, 1);
            step();
            check_val("timeout_busy", bus.busy, 0);
        end
    endtask

    logic [191:0] b44;
    logic [2:0]   conf;
    int lo_t[8] = '{0, 32, 0, 32, 0, 32, 0, 40};
    int hi_t[8] = '{-1, 62, -1, 62, -1, 62, -1, 41};
    int sc_t[8] = '{3, 34, 34, 65, 65, 96, 96, 98};
    int mv_t[8] = '{18, 17, 16, 15, 14, 13, 12, 11};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.btn_ok = 0; bus.btn_new = 0; bus.gen_done = 0; bus.elim_done = 0;
        bus.gen_board = '0; bus.elim_board = '0;
        #12;
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_board", bus.board, 0);
        check_val("rst_moves", bus.moves_left, 0);
        check_val("rst_strobes", {bus.gen_req, bus.confirm, bus.game_over}, 0);
        step();
        rst_n = 1'b1;
        step();
        check_val("idle_busy", bus.busy, 1);

        // round start
        bus.btn_new = 1'b1;
        step();
        bus.btn_new = 1'b0;
        check_val("gen_req_hi", bus.gen_req, 1);
        step();
        check_val("gen_req_lo", bus.gen_req, 0);
        bus.gen_board = checker_board();
        bus.gen_done = 1'b1;
        step();
        bus.gen_done = 1'b0;
        check_val("play_busy", bus.busy, 0);
        check_val("play_score", bus.score, 0);
        check_val("play_moves", bus.moves_left, 20);
        check_val("play_board", bus.board, checker_board());
        check_val("play_cursor", {bus.cursor_x, bus.cursor_y}, 0);

        // up beats right in the same cycle; up at x=0 saturates or wraps
        bus.btn_up = 1'b1; bus.btn_right = 1'b1;
        step();
        bus.btn_up = 1'b0; bus.btn_right = 1'b0;
`ifdef ELIM_CTRL_CURSOR_WRAP_EN
        check_val("up_edge_x", bus.cursor_x, 7);
`else
        check_val("up_edge_x", bus.cursor_x, 0);
`endif
        check_val("up_prio_y", bus.cursor_y, 0);
`ifdef ELIM_CTRL_CURSOR_WRAP_EN
        bus.btn_down = 1'b1;
        step();
        bus.btn_down = 1'b0;
        check_val("down_wrap_x", bus.cursor_x, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            bus.btn_right = 1'b1;
            step();
            bus.btn_right = 1'b0;
            step();
        end
        check_val("right3_y", bus.cursor_y, 3);

        // (0,3) is empty in the checkerboard: ok ignored
        bus.btn_ok = 1'b1;
        step();
        bus.btn_ok = 1'b0;
        check_val("ok_empty_busy", bus.busy, 0);
        bus.btn_right = 1'b1;
        step();
        bus.btn_right = 1'b0;
        check_val("cursor_04", {bus.cursor_x, bus.cursor_y}, 8'h04);

        // move clearing cells 0,2,6
        b44 = checker_board();
        b44[0*3 +: 3] = 3'd0;
        b44[2*3 +: 3] = 3'd0;
        b44[6*3 +: 3] = 3'd0;
        do_move(b44, 1'b1, 1'b0, conf);
        check_val("m1_confirm_seq", conf, 3'b010);
        check_val("m1_board", bus.board, b44);
        check_val("m1_score", bus.score, 3);
        check_val("m1_moves", bus.moves_left, 19);
        check_val("m1_cursor_frozen", {bus.cursor_x, bus.cursor_y}, 8'h04);

        // timeout with no elim_done
        do_move('0, 1'b0, 1'b0, conf);
        check_val("to_board", bus.board, b44);
        check_val("to_score", bus.score, 3);
        check_val("to_moves", bus.moves_left, 19);

        for (int i = 0; i < 8; i++) begin
            do_move(fill_board(lo_t[i], hi_t[i]), 1'b1, (i == 0), conf);
            check_val($sformatf("c%0d_score", i), bus.score, sc_t[i]);
            check_val($sformatf("c%0d_moves", i), bus.moves_left, mv_t[i]);
        end
        for (int i = 0; i < 10; i++) begin
            do_move(fill_board(0, -1), 1'b1, 1'b0, conf);
            check_val($sformatf("f%0d_moves", i), bus.moves_left, 10 - i);
        end
        check_val("pre_last_score", bus.score, 98);

        // last move: 98+5 clamps to 99 and ends the round
        do_move(fill_board(50, 54), 1'b1, 1'b0, conf);
        check_val("last_score", bus.score, 99);
        check_val("last_moves", bus.moves_left, 0);
        check_val("last_over", bus.game_over, 1);
        check_val("last_busy", bus.busy, 0);

        bus.btn_ok = 1'b1; bus.btn_down = 1'b1;
        step();
        bus.btn_ok = 1'b0; bus.btn_down = 1'b0;
        check_val("over_ok_busy", bus.busy, 0);
        check_val("over_cursor", {bus.cursor_x, bus.cursor_y}, 8'h04);
        step();
        check_val("over_confirm", bus.confirm, 0);
        check_val("over_hold", bus.game_over, 1);

        // new round from OVER, then reset in WAIT
        bus.btn_new = 1'b1;
        step();
        bus.btn_new = 1'b0;
        check_val("over_new_gen_req", bus.gen_req, 1);
        bus.gen_board = fill_board(0, -1);
        bus.gen_done = 1'b1;
        step();
        bus.gen_done = 1'b0;
        check_val("r2_moves", bus.moves_left, 20);
        check_val("r2_over_clr", bus.game_over, 0);
        bus.elim_board = fill_board(0, 9);
        bus.btn_ok = 1'b1;
        step();
        bus.btn_ok = 1'b0;
        step();
        step();
        step();
        check_val("r2_wait_busy", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("wrst_confirm", bus.confirm, 0);
        check_val("wrst_board", bus.board, 0);
        check_val("wrst_busy", bus.busy, 0);
        check_val("wrst_moves", bus.moves_left, 0);
        step();
        rst_n = 1'b1;
        bus.elim_done = 1'b1;
        step();
        step();
        bus.elim_done = 1'b0;
        check_val("post_rst_board", bus.board, 0);
        check_val("post_rst_idle", bus.busy, 1);
        check_val("post_rst_score", bus.score, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
